alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/result width; must equal the downstream ALU width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid input 1 and cmd_ready output 1: command handshake.
REQ-005 SHALL have ports cmd_op input 3, cmd_a input WIDTH, cmd_b input WIDTH: operation and operands.
REQ-006 SHALL have port cmd_use_acc  input  1  select accumulator as operand A.
REQ-007 SHALL have ports alu_a output WIDTH, alu_b output WIDTH, alu_op output 3: drive the combinational ALU.
REQ-008 SHALL have ports alu_result input WIDTH, alu_carry input 1, alu_zero input 1: ALU return path.
REQ-009 SHALL have ports rsp_valid output 1 and rsp_ready input 1: response handshake.
REQ-010 SHALL have ports rsp_result output WIDTH, rsp_carry output 1, rsp_zero output 1: registered response.
REQ-011 SHALL have port acc  output  WIDTH  current accumulator value.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-013 IDLE: cmd_valid&cmd_ready at edge N SHALL latch op/a/b into operand registers and enter EXEC.
REQ-014 alu_a/alu_b/alu_op SHALL come directly from operand registers: glitch-free, held stable in every state.
REQ-015 EXEC lasts exactly one cycle; at its closing edge (N+1) SHALL capture alu_result/carry/zero into rsp regs, write alu_result to acc, enter RESP.
REQ-016 rsp_valid SHALL be 1 exactly in RESP (first at cycle N+2); fixed 2-cycle accept-to-valid latency.
REQ-017 RESP: rsp_ready=1 SHALL return to IDLE next edge; rsp_ready=0 SHALL hold rsp_* and acc unchanged indefinitely.
REQ-018 No overlap: at most one command in flight; cmd_valid outside IDLE SHALL be ignored (not accepted, not lost by sender).
REQ-019 rsp_* SHALL keep last captured values after handshake until next EXEC capture.
REQ-020 Flags SHALL be passed through unmodified (carry meaningful only for op 000, per ALU); no internal arithmetic.
REQ-021 acc SHALL take the WIDTH-bit result modulo 2^WIDTH; carry never enters acc.
REQ-022 Back-to-back: minimum command spacing SHALL be 3 cycles (IDLE, EXEC, RESP with rsp_ready=1).

Reset
REQ-023 rst SHALL force IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, acc=0, operand registers and alu_a/alu_b/alu_op=0.
REQ-024 rst in EXEC or RESP SHALL abandon the command; no response issued, acc=0.
REQ-025 rst SHALL override any simultaneous cmd or rsp handshake.

Configuration
REQ-026 With ALU_SEQ_ACC_EN defined, cmd_use_acc=1 SHALL latch acc (value at accept edge) as operand A instead of cmd_a.
REQ-027 Without ALU_SEQ_ACC_EN, cmd_use_acc SHALL be ignored, operand A always cmd_a; acc still updates and is visible.

Structure
REQ-028 Shared package alu_pkg SHALL hold op encodings (ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, SHL 110, SHR 111) and the FSM state enum.
REQ-029 No sub-module; ALU is instantiated beside alu_seq by the parent and wired via alu_* ports.

Verification
REQ-030 ADD a=20,b=15, rsp_ready=1 -> rsp_valid at cycle +2, rsp_result=3, rsp_carry=1, rsp_zero=0, acc=3.
REQ-031 SUB a=7,b=7 -> rsp_result=0, rsp_zero=1, rsp_carry=0.
REQ-032 XOR a=5'h1F,b=5'h0A with rsp_ready=0 for 4 cycles -> rsp_valid held, rsp_result=5'h15 stable, cmd_ready=0 throughout; cmd_valid asserted meanwhile not accepted.
REQ-033 ACC_EN defined: ADD 3+4, then ADD use_acc=1,b=10 -> second result 17; without macro same stimulus with cmd_a=0 -> 10.
REQ-034 rst asserted during EXEC of SHL a=9 -> next cycle IDLE, rsp_valid=0, acc=0, no response ever emitted.
REQ-035 Three back-to-back commands with cmd_valid and rsp_ready held 1 -> accepts exactly every 3 cycles, responses in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and the combinational ALU beside it:
// operation encodings and the sequencer FSM state type.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq.sv
// Single-command sequencer around an external combinational ALU with an accumulator.
// Optional macro ALU_SEQ_ACC_EN lets cmd_use_acc select the accumulator as operand A.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc
);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] oper_a;

`ifdef ALU_SEQ_ACC_EN
    assign oper_a = cmd_use_acc ? acc_q : cmd_a;
`else
    logic use_acc_unused;
    assign use_acc_unused = cmd_use_acc;
    assign oper_a         = cmd_a;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        acc_d        = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = oper_a;
                    b_d     = cmd_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Flags pass through untouched; carry never reaches the accumulator.
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                acc_d        = alu_result;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            acc_q        <= acc_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed commands push expected responses, a
// monitor pops and compares on each response handshake. Includes a reference ALU.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'b000;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         cmd_use_acc = 1'b0;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_carry, alu_zero;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_zero;
    logic [W-1:0] acc;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic [W-1:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .acc(acc)
    );

    // Reference combinational ALU; carry is only produced by ADD, shifts are by one.
    always_comb begin
        logic [W:0] sum;
        sum       = '0;
        alu_carry = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[W-1:0];
                alu_carry  = sum[W];
            end
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOT:  alu_result = ~alu_a;
            OP_SHL:  alu_result = alu_a << 1;
            default: alu_result = alu_a >> 1;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each response handshake is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                    check("rsp_carry",  32'(rsp_carry),  32'(e.carry));
                    check("rsp_zero",   32'(rsp_zero),   32'(e.zero));
                    check("acc",        32'(acc),        32'(e.acc));
                    $display("rsp res=%0h c=%0b z=%0b acc=%0h cycle %0d",
                             rsp_result, rsp_carry, rsp_zero, acc, cyc);
                end
            end
        end
    end

    // Call just after a posedge. Returns just after the accepting posedge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ua, input bit push, input logic [W-1:0] er,
                        input logic ec, input logic ez, input logic [W-1:0] ea,
                        input bit hold, output int acc_cyc);
        exp_t e;
        bit   ok;
        ok          = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 32'd1, 32'd0);
            acc_cyc = -1;
        end else begin
            e.res   = er;
            e.carry = ec;
            e.zero  = ez;
            e.acc   = ea;
            if (push) exp_q.push_back(e);
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            $display("cmd op=%0d a=%0h b=%0h use_acc=%0b accepted cycle %0d", op, a, b, ua, cyc);
        end
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        int c0, c1, c2, c3;
        logic [W-1:0] exp_acc2;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_alu_regs", 32'({alu_a, alu_b, alu_op}), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;

        // ADD 20+15 wraps to 3 with carry; check the 2-cycle accept-to-valid latency.
        send(OP_ADD, 5'd20, 5'd15, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b0, c0);
        @(negedge clk);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_alu_drive", 32'({alu_a, alu_b, alu_op}), 32'({5'd20, 5'd15, 3'b000}));
        @(negedge clk);
        check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;

        // SUB 7-7 -> zero
        send(OP_SUB, 5'd7, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, c0);
        repeat (3) @(posedge clk);
        #1;

        // XOR held in RESP with rsp_ready=0 while another command is offered.
        rsp_ready = 1'b0;
        send(OP_XOR, 5'h1F, 5'h0A, 1'b0, 1'b1, 5'h15, 1'b0, 1'b0, 5'h15, 1'b0, c0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 5'd1;
        cmd_b     = 5'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_result", 32'(rsp_result), 32'h15);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_acc", 32'(acc), 32'h15);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_rsp_result", 32'(rsp_result), 32'h15);
        @(negedge clk);
        check("ignored_cmd_not_taken", 32'({cmd_ready, rsp_valid}), 32'b10);
        @(posedge clk);
        #1;

        // Accumulator as operand A (only with ALU_SEQ_ACC_EN).
`ifdef ALU_SEQ_ACC_EN
        exp_acc2 = 5'd17;
`else
        exp_acc2 = 5'd10;
`endif
        send(OP_ADD, 5'd3, 5'd4, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd7, 1'b0, c0);
        repeat (3) @(posedge clk);
        #1;
        send(OP_ADD, 5'd0, 5'd10, 1'b1, 1'b1, exp_acc2, 1'b0, 1'b0, exp_acc2, 1'b0, c0);
        repeat (3) @(posedge clk);
        #1;
        cmd_use_acc = 1'b0;

        // Reset during EXEC abandons the command.
        send(OP_SHL, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, c0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_acc", 32'(acc), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Back-to-back with cmd_valid and rsp_ready held high.
        send(OP_ADD, 5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, c1);
        send(OP_OR, 5'h10, 5'h01, 1'b0, 1'b1, 5'h11, 1'b0, 1'b0, 5'h11, 1'b1, c2);
        send(OP_AND, 5'h1C, 5'h07, 1'b0, 1'b1, 5'h04, 1'b0, 1'b0, 5'h04, 1'b0, c3);
        check("b2b_spacing_1", 32'(c2 - c1), 32'd3);
        check("b2b_spacing_2", 32'(c3 - c2), 32'd3);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
